// File: rtl/mmcm_lock_supervisor.sv
// mmcm_lock_supervisor
//   Sequences the board MMCM from the free-running input clock. It pulses the
//   MMCM reset and watches LOCKED through a 2-FF synchroniser. It debounces the
//   lock, times out and retries, and finally releases the system reset. It
//   faults after too many failed attempts.
//
// Ports
//   clk_in           free-running input clock (sole clock)
//   reset            async active-high reset
//   mmcm_locked      MMCM LOCKED, asynchronous to clk_in
//   clear_fault      sync pulse: leaves FAULT, clears lock_lost_sticky
//   mmcm_reset       to MMCM RST, active high
//   sys_rst          active-high system reset for MMCM-clocked logic
//   clocks_ok        high only in RUN
//   lock_lost_sticky set when lock is lost while in RUN
//   retry_count      timeout retries since last RUN entry or fault clear
//   fault            high in FAULT
//
// state       | meaning
// ------------+---------------------------------------------------------
// RESET_MMCM  | hold MMCM in reset for RST_PULSE_CYCLES
// WAIT_LOCK   | MMCM running, waiting for lock, timeout -> retry/fault
// STABILIZE   | lock seen, require LOCK_STABLE_CYCLES of continuous lock
// RELEASE_DLY | lock stable, hold sys_rst a further RELEASE_DELAY_CYCLES
// RUN         | clocks good, system out of reset
// FAULT       | retries exhausted, MMCM held in reset until clear_fault

module mmcm_lock_supervisor #(
  parameter int RST_PULSE_CYCLES     = 16,
  parameter int LOCK_TIMEOUT_CYCLES  = 100000,
  parameter int LOCK_STABLE_CYCLES   = 1024,
  parameter int RELEASE_DELAY_CYCLES = 64,
  parameter int MAX_RETRIES          = 15,
  parameter int CNT_WIDTH            = 20
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       mmcm_locked,
  input  logic       clear_fault,
  output logic       mmcm_reset,
  output logic       sys_rst,
  output logic       clocks_ok,
  output logic       lock_lost_sticky,
  output logic [3:0] retry_count,
  output logic       fault
);

  typedef enum logic [2:0] {
    RESET_MMCM,
    WAIT_LOCK,
    STABILIZE,
    RELEASE_DLY,
    RUN,
    FAULT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] RST_LAST     = CNT_WIDTH'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RELEASE_LAST = CNT_WIDTH'(RELEASE_DELAY_CYCLES - 1);
  localparam logic [3:0]           RETRY_MAX    = 4'(MAX_RETRIES);

  state_t               state;
  logic [CNT_WIDTH-1:0] counter;
  logic                 locked_meta;
  logic                 locked_s;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= mmcm_locked;
      locked_s    <= locked_meta;
    end
  end

  // Outputs are updated together with the state transition that changes them,
  // so every output is a registered copy of what the new state implies.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state            <= RESET_MMCM;
      counter          <= '0;
      mmcm_reset       <= 1'b1;
      sys_rst          <= 1'b1;
      clocks_ok        <= 1'b0;
      fault            <= 1'b0;
      lock_lost_sticky <= 1'b0;
      retry_count      <= 4'd0;
    end else begin
      // A lock-loss set further down overrides this clear in the same cycle.
      if (clear_fault) lock_lost_sticky <= 1'b0;

      case (state)
        RESET_MMCM: begin
          if (counter == RST_LAST) begin
            state      <= WAIT_LOCK;
            counter    <= '0;
            mmcm_reset <= 1'b0;
          end else begin
            counter <= counter + CNT_WIDTH'(1);
          end
        end

        WAIT_LOCK: begin
          if (locked_s) begin
            state   <= STABILIZE;
            counter <= '0;
          end else if (counter == TIMEOUT_LAST) begin
            counter    <= '0;
            mmcm_reset <= 1'b1;
            if (retry_count == RETRY_MAX) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              state       <= RESET_MMCM;
              retry_count <= retry_count + 4'd1;
            end
          end else begin
            counter <= counter + CNT_WIDTH'(1);
          end
        end

        STABILIZE: begin
          if (!locked_s) begin
            state   <= WAIT_LOCK;
            counter <= '0;
          end else if (counter == STABLE_LAST) begin
            state   <= RELEASE_DLY;
            counter <= '0;
          end else begin
            counter <= counter + CNT_WIDTH'(1);
          end
        end

        RELEASE_DLY: begin
          if (!locked_s) begin
            state   <= WAIT_LOCK;
            counter <= '0;
          end else if (counter == RELEASE_LAST) begin
            state       <= RUN;
            counter     <= '0;
            sys_rst     <= 1'b0;
            clocks_ok   <= 1'b1;
            retry_count <= 4'd0;
          end else begin
            counter <= counter + CNT_WIDTH'(1);
          end
        end

        RUN: begin
          if (!locked_s) begin
            state            <= RESET_MMCM;
            counter          <= '0;
            mmcm_reset       <= 1'b1;
            sys_rst          <= 1'b1;
            clocks_ok        <= 1'b0;
            lock_lost_sticky <= 1'b1;
          end
        end

        FAULT: begin
          if (clear_fault) begin
            state       <= RESET_MMCM;
            counter     <= '0;
            fault       <= 1'b0;
            retry_count <= 4'd0;
          end
        end

        default: begin
          state      <= RESET_MMCM;
          counter    <= '0;
          mmcm_reset <= 1'b1;
          sys_rst    <= 1'b1;
          clocks_ok  <= 1'b0;
          fault      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmcm_lock_supervisor.sv
module tb_mmcm_lock_supervisor;

  localparam int P_RST     = 4;
  localparam int P_TIMEOUT = 32;
  localparam int P_STABLE  = 8;
  localparam int P_RELEASE = 4;
  localparam int P_RETRIES = 2;
  localparam int REL_LAT   = 3 + P_STABLE + P_RELEASE;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       mmcm_locked;
  logic       clear_fault;
  logic       mmcm_reset;
  logic       sys_rst;
  logic       clocks_ok;
  logic       lock_lost_sticky;
  logic [3:0] retry_count;
  logic       fault;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  mmcm_lock_supervisor #(
    .RST_PULSE_CYCLES    (P_RST),
    .LOCK_TIMEOUT_CYCLES (P_TIMEOUT),
    .LOCK_STABLE_CYCLES  (P_STABLE),
    .RELEASE_DELAY_CYCLES(P_RELEASE),
    .MAX_RETRIES         (P_RETRIES),
    .CNT_WIDTH           (8)
  ) dut (
    .clk_in          (clk_in),
    .reset           (reset),
    .mmcm_locked     (mmcm_locked),
    .clear_fault     (clear_fault),
    .mmcm_reset      (mmcm_reset),
    .sys_rst         (sys_rst),
    .clocks_ok       (clocks_ok),
    .lock_lost_sticky(lock_lost_sticky),
    .retry_count     (retry_count),
    .fault           (fault)
  );

  always #5 clk_in = ~clk_in;

  // Counts rising edges until the chosen output (0 = mmcm_reset, 1 = sys_rst)
  // is seen at val just after an edge. Returns -1 if the budget runs out.
  task automatic count_until(input int which, input logic val, output int n);
    logic s;
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk_in);
      #1;
      s = (which == 0) ? mmcm_reset : sys_rst;
      if (s === val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    reset = 1'b1;
    mmcm_locked = 1'b0;
    clear_fault = 1'b0;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int e;
    repeat (3) @(negedge clk_in);
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    e = exp_q.pop_front(); vectors++;
    if (mmcm_reset !== 1'(e)) begin miscompares++; $display("FAIL rst_mmcm_reset: got %b want %0d", mmcm_reset, e); end
    e = exp_q.pop_front(); vectors++;
    if (sys_rst !== 1'(e)) begin miscompares++; $display("FAIL rst_sys_rst: got %b want %0d", sys_rst, e); end
    e = exp_q.pop_front(); vectors++;
    if (clocks_ok !== 1'(e)) begin miscompares++; $display("FAIL rst_clocks_ok: got %b want %0d", clocks_ok, e); end
    e = exp_q.pop_front(); vectors++;
    if (fault !== 1'(e)) begin miscompares++; $display("FAIL rst_fault: got %b want %0d", fault, e); end
    e = exp_q.pop_front(); vectors++;
    if (lock_lost_sticky !== 1'(e)) begin miscompares++; $display("FAIL rst_sticky: got %b want %0d", lock_lost_sticky, e); end
    e = exp_q.pop_front(); vectors++;
    if (retry_count !== 4'(e)) begin miscompares++; $display("FAIL rst_retry: got %0d want %0d", retry_count, e); end
  endtask

  task automatic test_first_lock();
    int n, e;
    logic held;
    reset = 1'b0;
    exp_q.push_back(P_RST);
    count_until(0, 1'b0, n);
    e = exp_q.pop_front(); vectors++;
    if (n !== e) begin miscompares++; $display("FAIL first_pulse_len: got %0d want %0d", n, e); end
    held = 1'b1;
    repeat (10) begin
      @(negedge clk_in);
      if (sys_rst !== 1'b1 || mmcm_reset !== 1'b0) held = 1'b0;
    end
    vectors++;
    if (held !== 1'b1) begin miscompares++; $display("FAIL wait_lock_outputs: got %b want 1", held); end
    mmcm_locked = 1'b1;
    exp_q.push_back(REL_LAT);
    count_until(1, 1'b0, n);
    e = exp_q.pop_front(); vectors++;
    if (n !== e) begin miscompares++; $display("FAIL release_latency: got %0d want %0d", n, e); end
    vectors++;
    if (clocks_ok !== 1'b1) begin miscompares++; $display("FAIL clocks_ok_run: got %b want 1", clocks_ok); end
    vectors++;
    if (retry_count !== 4'd0) begin miscompares++; $display("FAIL retry_run: got %0d want 0", retry_count); end
  endtask

  task automatic test_lock_loss();
    int n, e;
    @(negedge clk_in);
    mmcm_locked = 1'b0;
    exp_q.push_back(3);
    count_until(1, 1'b1, n);
    e = exp_q.pop_front(); vectors++;
    if (n < 1 || n > e) begin miscompares++; $display("FAIL loss_latency: got %0d want 1..%0d", n, e); end
    vectors++;
    if (clocks_ok !== 1'b0) begin miscompares++; $display("FAIL loss_clocks_ok: got %b want 0", clocks_ok); end
    vectors++;
    if (lock_lost_sticky !== 1'b1) begin miscompares++; $display("FAIL loss_sticky: got %b want 1", lock_lost_sticky); end
    exp_q.push_back(P_RST);
    count_until(0, 1'b0, n);
    e = exp_q.pop_front(); vectors++;
    if (n !== e) begin miscompares++; $display("FAIL loss_pulse_len: got %0d want %0d", n, e); end
    @(negedge clk_in);
    mmcm_locked = 1'b1;
    exp_q.push_back(REL_LAT);
    count_until(1, 1'b0, n);
    e = exp_q.pop_front(); vectors++;
    if (n !== e) begin miscompares++; $display("FAIL relock_latency: got %0d want %0d", n, e); end
    vectors++;
    if (lock_lost_sticky !== 1'b1) begin miscompares++; $display("FAIL relock_sticky: got %b want 1", lock_lost_sticky); end
  endtask

  task automatic test_clear_collision();
    int n, e;
    @(negedge clk_in);
    clear_fault = 1'b1;
    @(negedge clk_in);
    clear_fault = 1'b0;
    vectors++;
    if (lock_lost_sticky !== 1'b0) begin miscompares++; $display("FAIL clear_in_run_sticky: got %b want 0", lock_lost_sticky); end
    vectors++;
    if (clocks_ok !== 1'b1 || sys_rst !== 1'b0) begin
      miscompares++; $display("FAIL clear_in_run_state: got ok=%b rst=%b want ok=1 rst=0", clocks_ok, sys_rst);
    end
    mmcm_locked = 1'b0;
    repeat (2) @(negedge clk_in);
    clear_fault = 1'b1;
    @(negedge clk_in);
    clear_fault = 1'b0;
    vectors++;
    if (lock_lost_sticky !== 1'b1) begin miscompares++; $display("FAIL collision_sticky: got %b want 1", lock_lost_sticky); end
    vectors++;
    if (sys_rst !== 1'b1) begin miscompares++; $display("FAIL collision_sys_rst: got %b want 1", sys_rst); end
    count_until(0, 1'b0, n);
    @(negedge clk_in);
    mmcm_locked = 1'b1;
    exp_q.push_back(REL_LAT);
    count_until(1, 1'b0, n);
    e = exp_q.pop_front(); vectors++;
    if (n !== e) begin miscompares++; $display("FAIL collision_relock: got %0d want %0d", n, e); end
  endtask

  task automatic test_async_reset();
    vectors++;
    if (lock_lost_sticky !== 1'b1 || clocks_ok !== 1'b1) begin
      miscompares++; $display("FAIL pre_async_state: got sticky=%b ok=%b want 1 1", lock_lost_sticky, clocks_ok);
    end
    @(negedge clk_in);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (mmcm_reset !== 1'b1) begin miscompares++; $display("FAIL async_mmcm_reset: got %b want 1", mmcm_reset); end
    vectors++;
    if (sys_rst !== 1'b1) begin miscompares++; $display("FAIL async_sys_rst: got %b want 1", sys_rst); end
    vectors++;
    if (clocks_ok !== 1'b0) begin miscompares++; $display("FAIL async_clocks_ok: got %b want 0", clocks_ok); end
    vectors++;
    if (lock_lost_sticky !== 1'b0) begin miscompares++; $display("FAIL async_sticky: got %b want 0", lock_lost_sticky); end
  endtask

  task automatic test_timeout_fault();
    int n, e;
    logic held;
    apply_reset();
    for (int k = 0; k <= P_RETRIES; k++) begin
      exp_q.push_back(P_RST);
      exp_q.push_back(P_TIMEOUT);
      exp_q.push_back((k < P_RETRIES) ? k + 1 : P_RETRIES);
      exp_q.push_back((k == P_RETRIES) ? 1 : 0);
      count_until(0, 1'b0, n);
      e = exp_q.pop_front(); vectors++;
      if (n !== e) begin miscompares++; $display("FAIL timeout_pulse_len[%0d]: got %0d want %0d", k, n, e); end
      count_until(0, 1'b1, n);
      e = exp_q.pop_front(); vectors++;
      if (n !== e) begin miscompares++; $display("FAIL timeout_gap[%0d]: got %0d want %0d", k, n, e); end
      e = exp_q.pop_front(); vectors++;
      if (retry_count !== 4'(e)) begin miscompares++; $display("FAIL timeout_retry[%0d]: got %0d want %0d", k, retry_count, e); end
      e = exp_q.pop_front(); vectors++;
      if (fault !== 1'(e)) begin miscompares++; $display("FAIL timeout_fault[%0d]: got %b want %0d", k, fault, e); end
    end
    held = 1'b1;
    repeat (50) begin
      @(negedge clk_in);
      if (mmcm_reset !== 1'b1 || sys_rst !== 1'b1 || fault !== 1'b1) held = 1'b0;
    end
    vectors++;
    if (held !== 1'b1) begin miscompares++; $display("FAIL fault_held: got %b want 1", held); end
  endtask

  task automatic test_fault_clear();
    int n, e;
    @(negedge clk_in);
    clear_fault = 1'b1;
    @(negedge clk_in);
    clear_fault = 1'b0;
    vectors++;
    if (fault !== 1'b0) begin miscompares++; $display("FAIL clear_fault_flag: got %b want 0", fault); end
    vectors++;
    if (retry_count !== 4'd0) begin miscompares++; $display("FAIL clear_retry: got %0d want 0", retry_count); end
    exp_q.push_back(P_RST);
    count_until(0, 1'b0, n);
    e = exp_q.pop_front(); vectors++;
    if (n !== e) begin miscompares++; $display("FAIL clear_new_pulse: got %0d want %0d", n, e); end
  endtask

  task automatic test_glitch();
    int n, e;
    logic held;
    held = 1'b1;
    @(negedge clk_in);
    mmcm_locked = 1'b1;
    repeat (5) begin
      @(negedge clk_in);
      if (sys_rst !== 1'b1) held = 1'b0;
    end
    mmcm_locked = 1'b0;
    repeat (2) begin
      @(negedge clk_in);
      if (sys_rst !== 1'b1) held = 1'b0;
    end
    mmcm_locked = 1'b1;
    exp_q.push_back(REL_LAT);
    count_until(1, 1'b0, n);
    vectors++;
    if (held !== 1'b1) begin miscompares++; $display("FAIL glitch_held_rst: got %b want 1", held); end
    e = exp_q.pop_front(); vectors++;
    if (n !== e) begin miscompares++; $display("FAIL glitch_release: got %0d want %0d", n, e); end
    vectors++;
    if (retry_count !== 4'd0) begin miscompares++; $display("FAIL glitch_retry: got %0d want 0", retry_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    mmcm_locked = 1'b0;
    clear_fault = 1'b0;
    test_reset();
    test_first_lock();
    test_lock_loss();
    test_clear_collision();
    test_async_reset();
    test_timeout_fault();
    test_fault_clear();
    test_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmcm_lock_supervisor.md
Name: mmcm_lock_supervisor

Overview:
Supervises the board-level MMCM clock generator from the free-running 100 MHz input clock.
- Drives the MMCM reset input.
- Watches the MMCM LOCKED output: synchronises it, debounces it, applies a timeout and retries.
- Produces the system reset and a clocks-ok status that gate all logic running on the MMCM output clocks.
- Sits directly upstream of the MMCM (feeds its reset) and downstream of it (consumes its lock).

Parameters:
RST_PULSE_CYCLES, 16, cycles mmcm_reset is held high per reset attempt (≥1).
LOCK_TIMEOUT_CYCLES, 100000, cycles allowed in WAIT_LOCK before a retry (1 ms at 100 MHz).
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before release.
RELEASE_DELAY_CYCLES, 64, extra cycles sys_rst is held after lock is declared stable.
MAX_RETRIES, 15, reset retries allowed after timeouts before FAULT (0 = fault on first timeout).
CNT_WIDTH, 20, shared counter width; must hold the largest cycle parameter minus 1.

Ports:
clk_in  input  1  free-running 100 MHz input clock (also the MMCM input clock); sole clock.
reset  input  1  asynchronous, active-high reset.
mmcm_locked  input  1  MMCM LOCKED; asynchronous to clk_in.
clear_fault  input  1  synchronous pulse; exits FAULT and clears the sticky flag.
mmcm_reset  output  1  to MMCM RST, active high.
sys_rst  output  1  active-high system reset; consumers resynchronise it per clock domain.
clocks_ok  output  1  1 only in RUN.
lock_lost_sticky  output  1  set on lock loss while in RUN.
retry_count  output  4  timeout retries since the last RUN entry or clear; saturates at MAX_RETRIES.
fault  output  1  1 in FAULT.

Behaviour:
- Clock and reset: one clock (clk_in). Reset is asynchronous, active-high (reset).
- Lock synchroniser: mmcm_locked passes through a 2-FF synchroniser (reset to 0) to form locked_s. Only locked_s is used internally.
- Outputs: all registered. They are Moore outputs of the state, except lock_lost_sticky and retry_count, which are registered flags.
- Reset values (async, no clock needed):
  - state = RESET_MMCM, counter = 0.
  - mmcm_reset = 1, sys_rst = 1.
  - clocks_ok = 0, fault = 0, lock_lost_sticky = 0, retry_count = 0.
- RESET_MMCM:
  - mmcm_reset = 1, sys_rst = 1.
  - Count RST_PULSE_CYCLES cycles, then go to WAIT_LOCK with counter = 0.
- WAIT_LOCK:
  - mmcm_reset = 0, sys_rst = 1.
  - locked_s = 1 → STABILIZE, counter = 0.
  - Otherwise count. At counter = LOCK_TIMEOUT_CYCLES-1, perform a timeout:
    - if retry_count = MAX_RETRIES → FAULT;
    - else retry_count += 1 → RESET_MMCM.
- STABILIZE:
  - sys_rst = 1.
  - locked_s = 0 → WAIT_LOCK with counter = 0; retry_count is not incremented.
  - After LOCK_STABLE_CYCLES consecutive locked_s = 1 cycles → RELEASE_DLY.
- RELEASE_DLY:
  - sys_rst = 1.
  - locked_s = 0 → WAIT_LOCK with counter = 0.
  - After RELEASE_DELAY_CYCLES cycles → RUN.
- RUN:
  - sys_rst = 0, clocks_ok = 1; retry_count cleared on entry.
  - locked_s = 0 → RESET_MMCM. On that transition: sys_rst = 1, clocks_ok = 0, lock_lost_sticky = 1. This is not counted as a retry.
- FAULT:
  - mmcm_reset = 1, sys_rst = 1, fault = 1.
  - clear_fault = 1 → RESET_MMCM, retry_count = 0, fault = 0.
- Release latency: sys_rst falls exactly 3 + LOCK_STABLE_CYCLES + RELEASE_DELAY_CYCLES clk_in edges after the first edge at which mmcm_locked is sampled high. This assumes the lock stays high, counting from WAIT_LOCK. clocks_ok rises on the same edge as the sys_rst fall.
- Lock-loss latency: sys_rst rises within 3 edges of mmcm_locked falling in RUN.
- clear_fault outside FAULT: clears lock_lost_sticky only.
- Set/clear collision: if clear_fault and a lock-loss event fall in the same cycle, the set wins and lock_lost_sticky = 1.
- Glitch on mmcm_locked shorter than one cycle: may or may not be seen. If it is seen, it follows the rules above; no metastable propagation.
- reset asserted mid-operation (any state): immediate return to reset values; the sequence restarts from RESET_MMCM.

Test Plan:
Parameters for all scenarios: RST_PULSE_CYCLES = 4, LOCK_TIMEOUT_CYCLES = 32, LOCK_STABLE_CYCLES = 8, RELEASE_DELAY_CYCLES = 4, MAX_RETRIES = 2.
1. Deassert reset; mmcm_locked rises 10 cycles after mmcm_reset falls → mmcm_reset high exactly 4 cycles; sys_rst falls and clocks_ok rises 15 edges after lock is first sampled; retry_count = 0.
2. mmcm_locked held 0 → three 4-cycle mmcm_reset pulses spaced 32 cycles apart; retry_count goes 1 then 2; fault = 1 after the third timeout; mmcm_reset then held 1 and sys_rst = 1.
3. mmcm_locked high 5 cycles, low 2, then high → stays in reset through the glitch; retry_count unchanged; sys_rst falls 15 edges after the second rise.
4. In RUN, drop mmcm_locked → sys_rst = 1 and clocks_ok = 0 within 3 edges; lock_lost_sticky = 1; 4-cycle mmcm_reset pulse; relock then returns to RUN with sticky still 1.
5. In FAULT, pulse clear_fault → fault = 0, retry_count = 0, a new mmcm_reset pulse starts. In RUN, drive clear_fault in the same cycle as a lock-loss event → lock_lost_sticky = 1.
6. Assert reset mid-RUN without a clock edge → mmcm_reset = 1, sys_rst = 1, clocks_ok = 0, lock_lost_sticky = 0 immediately.
